// File: rtl/cache_line_ctrl_if.sv
// cache_line_ctrl_if
//   Bundles the CPU request handshake, the tag/dirty status from the cache
//   array, the RAM burst handshake and the cache array controls for
//   cache_line_ctrl.
//   master : requester / cache array / RAM side (drives requests, status, ram_ack)
//   slave  : the controller (drives req_ready, RAM strobes, cache controls, done/err)
interface cache_line_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             req_valid;
  logic [1:0]       req_op;
  logic             req_indirect;
  logic             req_ready;
  logic             is_hit;
  logic             is_clean;
  logic             ram_ack;
  logic             ram_rd_en;
  logic             ram_wr_en;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       cache_in;
  logic             fill_we;
  logic             data_in_sel;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_op, req_indirect, is_hit, is_clean, ram_ack,
    input  req_ready, ram_rd_en, ram_wr_en, word_idx, cache_in, fill_we,
           data_in_sel, done, err
  );

  modport slave (
    input  req_valid, req_op, req_indirect, is_hit, is_clean, ram_ack,
    output req_ready, ram_rd_en, ram_wr_en, word_idx, cache_in, fill_we,
           data_in_sel, done, err
  );
endinterface

// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl
//   Write-back, write-allocate cache line controller. Accepts clear/read/write
//   requests, looks the line up, writes back a dirty victim and fills the line
//   from RAM as LINE_WORDS-beat bursts, then performs the CPU access. Indirect
//   requests repeat the lookup/access sequence up to MAX_IND extra times and
//   end in err if the chain has not terminated by then.
// Ports
//   clk        : clock, all state on rising edge
//   clr        : synchronous active-high reset
//   bus.slave  : req_valid/req_op/req_indirect/req_ready  CPU handshake
//                is_hit/is_clean                          tag/dirty status (CHECK)
//                ram_ack/ram_rd_en/ram_wr_en/word_idx     RAM burst
//                cache_in/fill_we/data_in_sel             cache array control
//                done/err                                 one-cycle result pulses
module cache_line_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 2,
  parameter int MAX_IND    = 3
) (
  input logic              clk,
  input logic              clr,
  cache_line_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOOKUP,
    S_CHECK,
    S_WB,
    S_FILL,
    S_ACCESS,
    S_IND
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_RSVD  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;

  localparam logic [1:0] CI_CLEAR  = 2'b00;
  localparam logic [1:0] CI_LOOKUP = 2'b01;
  localparam logic [1:0] CI_HOLD   = 2'b10;
  localparam logic [1:0] CI_WRITE  = 2'b11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [2:0]       HOP_MAX  = 3'(MAX_IND);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             ind_q, ind_d;
  logic [2:0]       hop_q, hop_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ind_q   <= 1'b0;
      hop_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ind_q   <= ind_d;
      hop_q   <= hop_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.word_idx = idx_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ind_d   = ind_q;
    hop_d   = hop_q;
    idx_d   = idx_q;

    bus.req_ready   = 1'b0;
    bus.ram_rd_en   = 1'b0;
    bus.ram_wr_en   = 1'b0;
    bus.cache_in    = CI_HOLD;
    bus.fill_we     = 1'b0;
    bus.data_in_sel = 1'b0;
    bus.done        = 1'b0;
    bus.err         = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_op == OP_RSVD) begin
            // Reserved op: flagged combinationally and dropped.
            bus.err = 1'b1;
          end else begin
            op_d    = bus.req_op;
            ind_d   = bus.req_indirect;
            hop_d   = '0;
            state_d = (bus.req_op == OP_CLEAR) ? S_CLEAR : S_LOOKUP;
          end
        end
      end

      S_CLEAR: begin
        bus.cache_in = CI_CLEAR;
        bus.done     = 1'b1;
        state_d      = S_IDLE;
      end

      S_LOOKUP: begin
        bus.cache_in = CI_LOOKUP;
        state_d      = S_CHECK;
      end

      S_CHECK: begin
        if (bus.is_hit)        state_d = S_ACCESS;
        else if (bus.is_clean) state_d = S_FILL;
        else                   state_d = S_WB;
      end

      S_WB: begin
        bus.ram_wr_en = 1'b1;
        if (bus.ram_ack) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_FILL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_FILL: begin
        bus.ram_rd_en   = 1'b1;
        bus.data_in_sel = 1'b1;
        bus.fill_we     = bus.ram_ack;
        if (bus.ram_ack) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_ACCESS;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_ACCESS: begin
        bus.cache_in = (op_q == OP_WRITE) ? CI_WRITE : CI_HOLD;
        state_d      = S_IND;
      end

      S_IND: begin
        if (!ind_q) begin
          bus.done = 1'b1;
          state_d  = S_IDLE;
        end else if (hop_q < HOP_MAX) begin
          hop_d   = hop_q + 1'b1;
          state_d = S_LOOKUP;
        end else begin
          // Chain exhausted its hop budget: error instead of completion.
          bus.err = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
